// File: rtl/zion_riscv_bj_ex_seq.sv
// Branch/jump execute sequencer: one shared adder produces the link PC in EVAL and
// the target address in TGT. The branch condition is resolved in EVAL.
module zion_riscv_bj_ex_seq #(
  parameter bit RV64  = 1'b0,
  parameter bit C_EXT = 1'b1,
  localparam int CPU_WIDTH = RV64 ? 64 : 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic                 iBranch,
  input  logic                 iJump,
  input  logic                 iBeq,
  input  logic                 iBne,
  input  logic                 iBlt,
  input  logic                 iBge,
  input  logic                 iUnsignedFlg,
  input  logic [CPU_WIDTH-1:0] iPc,
  input  logic [CPU_WIDTH-1:0] iS1,
  input  logic [CPU_WIDTH-1:0] iS2,
  input  logic [CPU_WIDTH-1:0] iOffset,
  input  logic [1:0]           iLinkOffset,
  input  logic                 iFlush,
  output logic                 oValid,
  input  logic                 iReady,
  output logic                 oTaken,
  output logic [CPU_WIDTH-1:0] oTgtAddr,
  output logic [CPU_WIDTH-1:0] oLinkPc,
  output logic                 oLinkWe,
  output logic                 oMisalign,
  output logic                 oDecErr
);

  typedef enum logic [1:0] {IDLE, EVAL, TGT, DONE} state_t;

  state_t state_reg, state_next;

  logic                 op_branch_reg, op_jump_reg, op_unsigned_reg;
  logic [3:0]           op_type_reg;
  logic [CPU_WIDTH-1:0] op_pc_reg, op_s1_reg, op_s2_reg, op_offset_reg;
  logic [1:0]           op_link_offset_reg;

  logic                 taken_reg, link_we_reg, misalign_reg, dec_err_reg;
  logic [CPU_WIDTH-1:0] tgt_addr_reg, link_pc_reg;

  logic                 accept;
  logic [CPU_WIDTH-1:0] add_a, add_b, add_sum;
  logic signed [CPU_WIDTH:0] s1_ext, s2_ext;
  logic                 equal, less_than, dec_err, cond_taken, tgt_misalign;

  assign oReady = (state_reg == IDLE);
  assign oValid = (state_reg == DONE);
  assign accept = iValid & oReady & ~iFlush;

  // The single adder: link PC while evaluating, branch/jump target afterwards.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state_reg == TGT) begin
      add_a = op_branch_reg ? op_pc_reg : op_s1_reg;
      add_b = op_offset_reg;
    end else begin
      add_a = {CPU_WIDTH{op_jump_reg}} & op_pc_reg;
      add_b = {{(CPU_WIDTH-3){1'b0}}, op_link_offset_reg, 1'b0};
    end
  end
  assign add_sum = add_a + add_b;

  // One extra bit makes a single signed compare serve both signed and unsigned forms.
  assign s1_ext    = {~op_unsigned_reg & op_s1_reg[CPU_WIDTH-1], op_s1_reg};
  assign s2_ext    = {~op_unsigned_reg & op_s2_reg[CPU_WIDTH-1], op_s2_reg};
  assign equal     = (op_s1_reg == op_s2_reg);
  assign less_than = (s1_ext < s2_ext);

  assign dec_err    = (op_branch_reg == op_jump_reg) | (op_branch_reg & ~$onehot(op_type_reg));
  assign cond_taken = ~dec_err & (op_jump_reg
                    | (op_type_reg[3] & equal)     | (op_type_reg[2] & ~equal)
                    | (op_type_reg[1] & less_than) | (op_type_reg[0] & ~less_than));
  assign tgt_misalign = (C_EXT == 1'b0) && add_sum[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EVAL;
      EVAL:    state_next = cond_taken ? TGT : DONE;
      TGT:     state_next = DONE;
      DONE:    if (iReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (iFlush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_branch_reg      <= 1'b0;
      op_jump_reg        <= 1'b0;
      op_unsigned_reg    <= 1'b0;
      op_type_reg        <= '0;
      op_pc_reg          <= '0;
      op_s1_reg          <= '0;
      op_s2_reg          <= '0;
      op_offset_reg      <= '0;
      op_link_offset_reg <= '0;
      taken_reg          <= 1'b0;
      link_we_reg        <= 1'b0;
      misalign_reg       <= 1'b0;
      dec_err_reg        <= 1'b0;
      tgt_addr_reg       <= '0;
      link_pc_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          op_branch_reg      <= iBranch;
          op_jump_reg        <= iJump;
          op_unsigned_reg    <= iUnsignedFlg;
          op_type_reg        <= {iBeq, iBne, iBlt, iBge};
          op_pc_reg          <= iPc;
          op_s1_reg          <= iS1;
          op_s2_reg          <= iS2;
          op_offset_reg      <= iOffset;
          op_link_offset_reg <= iLinkOffset;
          taken_reg          <= 1'b0;
          link_we_reg        <= 1'b0;
          misalign_reg       <= 1'b0;
          dec_err_reg        <= 1'b0;
        end
        EVAL: begin
          link_pc_reg <= add_sum;
          dec_err_reg <= dec_err;
          taken_reg   <= 1'b0;
          link_we_reg <= 1'b0;
        end
        TGT: begin
          tgt_addr_reg <= {add_sum[CPU_WIDTH-1:1], 1'b0};
          if (tgt_misalign) begin
            misalign_reg <= 1'b1;
            taken_reg    <= 1'b0;
            link_we_reg  <= 1'b0;
          end else begin
            taken_reg    <= 1'b1;
            link_we_reg  <= op_jump_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign oTaken    = taken_reg;
  assign oTgtAddr  = tgt_addr_reg;
  assign oLinkPc   = link_pc_reg;
  assign oLinkWe   = link_we_reg;
  assign oMisalign = misalign_reg;
  assign oDecErr   = dec_err_reg;

endmodule

// File: tb/tb_zion_riscv_bj_ex_seq.sv
// Directed bench: an RV32 C_EXT=1 instance and a C_EXT=0 instance share all inputs.
module tb_zion_riscv_bj_ex_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iValid = 1'b0, iBranch = 1'b0, iJump = 1'b0;
  logic        iBeq = 1'b0, iBne = 1'b0, iBlt = 1'b0, iBge = 1'b0, iUnsignedFlg = 1'b0;
  logic [31:0] iPc = '0, iS1 = '0, iS2 = '0, iOffset = '0;
  logic [1:0]  iLinkOffset = '0;
  logic        iFlush = 1'b0, iReady = 1'b0;

  logic        oReady, oValid, oTaken, oLinkWe, oMisalign, oDecErr;
  logic [31:0] oTgtAddr, oLinkPc;
  logic        c0_ready, c0_valid, c0_taken, c0_link_we, c0_misalign, c0_dec_err;
  logic [31:0] c0_tgt_addr, c0_link_pc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zion_riscv_bj_ex_seq #(.RV64(1'b0), .C_EXT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .iValid(iValid), .oReady(oReady),
    .iBranch(iBranch), .iJump(iJump), .iBeq(iBeq), .iBne(iBne), .iBlt(iBlt), .iBge(iBge),
    .iUnsignedFlg(iUnsignedFlg), .iPc(iPc), .iS1(iS1), .iS2(iS2), .iOffset(iOffset),
    .iLinkOffset(iLinkOffset), .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .oTaken(oTaken), .oTgtAddr(oTgtAddr), .oLinkPc(oLinkPc), .oLinkWe(oLinkWe),
    .oMisalign(oMisalign), .oDecErr(oDecErr)
  );

  zion_riscv_bj_ex_seq #(.RV64(1'b0), .C_EXT(1'b0)) dut_c0 (
    .clk(clk), .rst_n(rst_n), .iValid(iValid), .oReady(c0_ready),
    .iBranch(iBranch), .iJump(iJump), .iBeq(iBeq), .iBne(iBne), .iBlt(iBlt), .iBge(iBge),
    .iUnsignedFlg(iUnsignedFlg), .iPc(iPc), .iS1(iS1), .iS2(iS2), .iOffset(iOffset),
    .iLinkOffset(iLinkOffset), .iFlush(iFlush), .oValid(c0_valid), .iReady(iReady),
    .oTaken(c0_taken), .oTgtAddr(c0_tgt_addr), .oLinkPc(c0_link_pc), .oLinkWe(c0_link_we),
    .oMisalign(c0_misalign), .oDecErr(c0_dec_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic br, jp, beq, bne, blt, bge, uns,
                       input logic [31:0] pc, s1, s2, off, input logic [1:0] lo);
    iBranch = br; iJump = jp; iBeq = beq; iBne = bne; iBlt = blt; iBge = bge;
    iUnsignedFlg = uns; iPc = pc; iS1 = s1; iS2 = s2; iOffset = off; iLinkOffset = lo;
  endtask

  // Issue one instruction, measure accept-edge-to-oValid latency, check, hold, retire.
  task automatic run(input string tag,
                     input logic br, jp, beq, bne, blt, bge, uns,
                     input logic [31:0] pc, s1, s2, off, input logic [1:0] lo,
                     input int exp_lat, input logic e_tk, input logic [31:0] e_tgt, e_link,
                     input logic e_we, e_mis, e_dec, input logic c0_tk, c0_mis, input int hold);
    int lat;
    @(negedge clk);
    drive(br, jp, beq, bne, blt, bge, uns, pc, s1, s2, off, lo);
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    lat = 1;
    while (!oValid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".taken"}, oTaken, e_tk);
    if (e_tk) check({tag, ".tgt"}, oTgtAddr, e_tgt);
    check({tag, ".link"}, oLinkPc, e_link);
    check({tag, ".we"}, oLinkWe, e_we);
    check({tag, ".mis"}, oMisalign, e_mis);
    check({tag, ".dec"}, oDecErr, e_dec);
    check({tag, ".c0_taken"}, c0_taken, c0_tk);
    check({tag, ".c0_mis"}, c0_misalign, c0_mis);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      iValid = 1'b1;
      iS1 = iS1 ^ 32'h5555_0000;
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, oValid, 1'b1);
      check({tag, ".hold_ready"}, oReady, 1'b0);
      check({tag, ".hold_tgt"}, oTgtAddr, e_tgt);
      check({tag, ".hold_taken"}, oTaken, e_tk);
    end
    @(negedge clk);
    iValid = 1'b0;
    iReady = 1'b1;
    @(posedge clk); #1;
    iReady = 1'b0;
    check({tag, ".ret_valid"}, oValid, 1'b0);
    check({tag, ".ret_ready"}, oReady, 1'b1);
    $display("txn %s lat=%0d taken=%0b tgt=0x%0h link=0x%0h we=%0b mis=%0b dec=%0b",
             tag, lat, oTaken, oTgtAddr, oLinkPc, oLinkWe, oMisalign, oDecErr);
  endtask

  initial begin
    int stray;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", oReady, 1'b1);
    check("rst.valid", oValid, 1'b0);
    check("rst.tgt", oTgtAddr, 32'h0);
    check("rst.link", oLinkPc, 32'h0);
    check("rst.taken", oTaken, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    //    tag        br jp eq ne lt ge u  pc            s1            s2            off           lo     lat tk tgt           link          we mis dec c0tk c0mis hold
    run("beq",       1, 0, 1, 0, 0, 0, 0, 32'h100,      32'h5,        32'h5,        32'h20,       2'b00, 3, 1, 32'h120,      32'h0,        0, 0, 0, 1, 0, 0);
    run("blt",       1, 0, 0, 0, 1, 0, 0, 32'h200,      32'hFFFFFFFF, 32'h1,        32'h10,       2'b00, 3, 1, 32'h210,      32'h0,        0, 0, 0, 1, 0, 0);
    run("bltu",      1, 0, 0, 0, 1, 0, 1, 32'h200,      32'hFFFFFFFF, 32'h1,        32'h10,       2'b00, 2, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
    run("jalr",      0, 1, 0, 0, 0, 0, 0, 32'h400,      32'h1001,     32'h0,        32'h2,        2'b10, 3, 1, 32'h1002,     32'h404,      1, 0, 0, 0, 1, 0);
    run("bne_mis",   1, 0, 0, 1, 0, 0, 0, 32'h100,      32'h1,        32'h2,        32'h6,        2'b00, 3, 1, 32'h106,      32'h0,        0, 0, 0, 0, 1, 0);
    run("jal_wrap",  0, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h8,        2'b10, 3, 1, 32'h4,        32'h0,        1, 0, 0, 1, 0, 0);
    run("jalr_c2",   0, 1, 0, 0, 0, 0, 0, 32'h800,      32'h900,      32'h0,        32'h10,       2'b01, 3, 1, 32'h910,      32'h802,      1, 0, 0, 1, 0, 0);
    run("bge_neg",   1, 0, 0, 0, 0, 1, 0, 32'h300,      32'h1,        32'hFFFFFFFF, 32'hFFFFFFF0, 2'b00, 3, 1, 32'h2F0,      32'h0,        0, 0, 0, 1, 0, 0);
    run("bgeu",      1, 0, 0, 0, 0, 1, 1, 32'h300,      32'h1,        32'hFFFFFFFF, 32'h10,       2'b00, 2, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
    run("dec_bj",    1, 1, 1, 0, 0, 0, 0, 32'h100,      32'h5,        32'h5,        32'h20,       2'b00, 2, 0, 32'h0,        32'h100,      0, 0, 1, 0, 0, 0);
    run("dec_mh",    1, 0, 1, 1, 0, 0, 0, 32'h100,      32'h5,        32'h6,        32'h20,       2'b00, 2, 0, 32'h0,        32'h0,        0, 0, 1, 0, 0, 0);
    run("bne_nt",    1, 0, 0, 1, 0, 0, 0, 32'h100,      32'h7,        32'h7,        32'h20,       2'b00, 2, 0, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0);
    run("bp_beq",    1, 0, 1, 0, 0, 0, 0, 32'h500,      32'h9,        32'h9,        32'h40,       2'b00, 3, 1, 32'h540,      32'h0,        0, 0, 0, 1, 0, 5);
    run("bp_next",   1, 0, 0, 0, 1, 0, 0, 32'h600,      32'h1,        32'h2,        32'h8,        2'b00, 3, 1, 32'h608,      32'h0,        0, 0, 0, 1, 0, 0);

    // Flush overrides an accept.
    @(negedge clk);
    drive(1, 0, 1, 0, 0, 0, 0, 32'h100, 32'h5, 32'h5, 32'h20, 2'b00);
    iValid = 1'b1;
    iFlush = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    iFlush = 1'b0;
    check("flush_acc.ready", oReady, 1'b1);
    $display("txn flush_acc ready=%0b", oReady);

    // Flush while in TGT: back to IDLE, never reports.
    @(negedge clk);
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    @(posedge clk); #1;
    iFlush = 1'b1;
    @(posedge clk); #1;
    iFlush = 1'b0;
    check("flush_tgt.ready", oReady, 1'b1);
    check("flush_tgt.valid", oValid, 1'b0);
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (oValid) stray++;
    end
    check("flush_tgt.no_valid", stray, 0);
    $display("txn flush_tgt ready=%0b stray_valid=%0d", oReady, stray);

    // Reset while in EVAL, with stale nonzero results from earlier instructions.
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0, 0, 32'h400, 32'h1001, 32'h0, 32'h2, 2'b10);
    iValid = 1'b1;
    @(posedge clk); #1;
    iValid = 1'b0;
    check("rst_eval.busy", oReady, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_eval.ready", oReady, 1'b1);
    check("rst_eval.valid", oValid, 1'b0);
    check("rst_eval.tgt", oTgtAddr, 32'h0);
    check("rst_eval.link", oLinkPc, 32'h0);
    check("rst_eval.taken", oTaken, 1'b0);
    $display("txn rst_eval ready=%0b tgt=0x%0h link=0x%0h", oReady, oTgtAddr, oLinkPc);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst",  1, 0, 1, 0, 0, 0, 0, 32'h100,      32'h5,        32'h5,        32'h20,       2'b00, 3, 1, 32'h120,      32'h0,        0, 0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zion_riscv_bj_ex_seq.md
Name: zion_riscv_bj_ex_seq

Overview:
Multi-cycle execute sequencer for RISC-V branch and jump instructions. It shares one CPU_WIDTH adder between link-PC generation and target-address generation, and evaluates the branch condition in between. It sits in the EX stage between decode and the PC-redirect/writeback logic. It uses a valid/ready handshake on both sides and accepts one instruction at a time.

Parameters:
RV64, 0, 1 = RV64 (CPU_WIDTH = 64); 0 = RV32 (CPU_WIDTH = 32)
C_EXT, 1, 1 = 2-byte target alignment is legal; 0 = 4-byte alignment is required

Ports:
clk  input  1  clock; all state is updated on its rising edge
rst_n  input  1  asynchronous active-low reset
iValid  input  1  decoded branch/jump instruction is present
oReady  output  1  sequencer can accept an instruction (high only in IDLE)
iBranch  input  1  instruction is a conditional branch
iJump  input  1  instruction is JAL/JALR (for JAL, decode places PC in iS1)
iBeq, iBne, iBlt, iBge  input  1 each  branch-type one-hot
iUnsignedFlg  input  1  BLTU/BGEU compare
iPc  input  CPU_WIDTH  instruction PC
iS1, iS2  input  CPU_WIDTH  source operands
iOffset  input  CPU_WIDTH  sign-extended immediate
iLinkOffset  input  2  link increment in halfwords (2'b10 = +4, 2'b01 = +2)
iFlush  input  1  pipeline flush
oValid  output  1  result is available
iReady  input  1  downstream accepts the result
oTaken  output  1  redirect the PC to oTgtAddr
oTgtAddr  output  CPU_WIDTH  target address, bit 0 forced to 0
oLinkPc  output  CPU_WIDTH  return address
oLinkWe  output  1  write oLinkPc to rd
oMisalign  output  1  instruction-address-misaligned exception
oDecErr  output  1  illegal decode combination

Behaviour:
- States: IDLE, EVAL, TGT, DONE. Reset puts the FSM in IDLE.
- Reset values: all result registers 0, oValid=0, oReady=1. Reset asserted mid-operation drops the instruction immediately, with no output.
- Operand capture:
  - Accept = iValid & oReady & !iFlush.
  - On accept, register all operand inputs; the inputs are not sampled again.
  - Go IDLE->EVAL.
- EVAL:
  - Shared adder computes ({CPU_WIDTH{jump}} & pc) + {linkOffset,1'b0}; this value is registered into oLinkPc.
  - Condition evaluation:
    - equal = (s1 == s2).
    - lessThan = signed compare on operands extended by one bit, where extension bit = ~unsigned & MSB.
    - taken = jump | beq&equal | bne&!equal | blt&lessThan | bge&!lessThan.
  - Next state is TGT if taken, else DONE with oTaken=0 and oLinkWe=0.
- Decode error:
  - Condition: iBranch==iJump, or (iBranch and the branch-type vector is not one-hot).
  - Response: taken forced to 0, oDecErr=1, next state DONE.
- TGT:
  - Shared adder computes base + offset, with base = pc for branch and s1 for jump.
  - Result bit 0 is cleared; the result is registered into oTgtAddr.
  - If C_EXT=0 and result bit 1 = 1: oMisalign=1, oTaken=0, oLinkWe=0.
  - Otherwise: oTaken=1, oLinkWe=jump.
  - Next state DONE.
- DONE: oValid=1 and all outputs are held stable until iReady. On oValid&iReady, go to IDLE; oReady=1 in the next cycle.
- Latency from the accept edge:
  - Not-taken or decode error: oValid at the 2nd rising edge.
  - Taken: oValid at the 3rd rising edge.
  - Minimum initiation interval is 3 or 4 cycles respectively.
- iFlush:
  - In any state, the next state is IDLE and oValid deasserts the next cycle.
  - Flush wins over an accept and over a DONE handshake; a flushed instruction never reports a result.
  - Result registers hold their stale values and are ignored.
- Arithmetic: all adds are modulo 2^CPU_WIDTH and wrap silently (for example PC 0xFFFFFFFC + 4 = 0).
- oDecErr, oMisalign and oTaken clear when a new instruction enters EVAL.

Test Plan:
- BEQ, RV32, pc=0x100, s1=s2=5, off=0x20 -> oValid 3 cycles after accept; oTaken=1, oTgtAddr=0x120, oLinkWe=0.
- BLT, s1=0xFFFFFFFF, s2=1:
  - unsigned=0 -> taken.
  - BLTU, same operands -> oValid 2 cycles after accept; oTaken=0, oMisalign=0.
- JALR, s1=0x1001, off=0x2, pc=0x400, linkOffset=2'b10 -> oTgtAddr=0x1002, oLinkPc=0x404, oLinkWe=1.
- C_EXT=0, BNE taken, pc=0x100, off=0x6 -> oMisalign=1, oTaken=0, oLinkWe=0; with C_EXT=1 -> oTaken=1, oTgtAddr=0x106.
- Backpressure: hold iReady=0 for 5 cycles in DONE -> outputs and oValid stable, oReady=0, further iValid ignored. Then iReady=1 -> IDLE, next instruction accepted one cycle later.
- Flush and reset:
  - iFlush in TGT -> IDLE next cycle, no oValid.
  - rst_n low in EVAL -> outputs zero immediately, oReady=1.
  - iBranch=iJump=1 -> oDecErr=1, oTaken=0.
